// File: rtl/pmci_spi_csr_seq.sv
// PMCI SPI_CSR sequencer: turns a single flash read/write command into the
// Avalon-MM register sequence (data, address, go, busy poll, read-back).
module pmci_spi_csr_seq #(
   parameter logic [31:0] BASE_ADDR  = 32'h20000,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] avmm_address,
   output logic        avmm_write,
   output logic        avmm_read,
   output logic [31:0] avmm_writedata,
   output logic [3:0]  avmm_byteenable,
   input  logic        avmm_waitrequest,
   input  logic [31:0] avmm_readdata,
   input  logic        avmm_readdatavalid
);

   localparam int          CW        = $clog2(POLL_LIMIT + 1);
   localparam logic [31:0] SPI_CSR   = BASE_ADDR + 32'h400;
   localparam logic [31:0] SPI_AR    = BASE_ADDR + 32'h404;
   localparam logic [31:0] SPI_RD_DR = BASE_ADDR + 32'h408;
   localparam logic [31:0] SPI_WR_DR = BASE_ADDR + 32'h40C;
   localparam logic [CW-1:0] POLL_LAST = CW'(POLL_LIMIT - 1);
   localparam logic [CW-1:0] POLL_MAX  = CW'(POLL_LIMIT);

   typedef enum logic [3:0] {
      IDLE, WR_WDR, WR_AR, WR_CSR, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT, RESP
   } state_t;

   state_t        state, state_nxt;
   logic          alive;      // cmd_ready held off until the first edge after reset
   logic          wr_q;
   logic [31:0]   addr_q, wdata_q;
   logic [CW-1:0] poll_cnt;
   logic          accept, timeout, busy_poll;

   assign cmd_ready = alive && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = cmd_valid && cmd_ready;
   assign busy_poll = (state == POLL_WAIT) && avmm_readdatavalid && avmm_readdata[31];

   // Next state and Avalon request outputs; requests are a pure function of
   // state so they stay frozen while waitrequest holds the state.
   always_comb begin
      state_nxt       = state;
      timeout         = 1'b0;
      avmm_address    = '0;
      avmm_write      = 1'b0;
      avmm_read       = 1'b0;
      avmm_writedata  = '0;
      avmm_byteenable = '0;
      case (state)
         IDLE: if (accept) state_nxt = cmd_write ? WR_WDR : WR_AR;
         WR_WDR: begin
            avmm_write      = 1'b1;
            avmm_address    = SPI_WR_DR;
            avmm_writedata  = wdata_q;
            avmm_byteenable = 4'hF;
            if (!avmm_waitrequest) state_nxt = WR_AR;
         end
         WR_AR: begin
            avmm_write      = 1'b1;
            avmm_address    = SPI_AR;
            avmm_writedata  = addr_q;
            avmm_byteenable = 4'hF;
            if (!avmm_waitrequest) state_nxt = WR_CSR;
         end
         WR_CSR: begin
            avmm_write      = 1'b1;
            avmm_address    = SPI_CSR;
            avmm_writedata  = {30'b0, wr_q, ~wr_q};
            avmm_byteenable = 4'hF;
            if (!avmm_waitrequest) state_nxt = POLL_REQ;
         end
         POLL_REQ: begin
            avmm_read       = 1'b1;
            avmm_address    = SPI_CSR;
            avmm_byteenable = 4'hF;
            if (!avmm_waitrequest) state_nxt = POLL_WAIT;
         end
         POLL_WAIT: begin
            if (avmm_readdatavalid) begin
               if (!avmm_readdata[31]) begin
                  state_nxt = wr_q ? RESP : RD_REQ;
               end else if (poll_cnt == POLL_LAST) begin
                  state_nxt = RESP;
                  timeout   = 1'b1;
               end else begin
                  state_nxt = POLL_REQ;
               end
            end
         end
         RD_REQ: begin
            avmm_read       = 1'b1;
            avmm_address    = SPI_RD_DR;
            avmm_byteenable = 4'hF;
            if (!avmm_waitrequest) state_nxt = RD_WAIT;
         end
         RD_WAIT: if (avmm_readdatavalid) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and post-reset ready enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   // Command capture, poll counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         poll_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else if (accept) begin
         wr_q      <= cmd_write;
         addr_q    <= cmd_addr;
         wdata_q   <= cmd_wdata;
         poll_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         // saturate rather than wrap; timeout leaves POLL_WAIT at the limit anyway
         if (busy_poll && poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + 1'b1;
         if (state == RD_WAIT && avmm_readdatavalid) rsp_rdata <= avmm_readdata;
         if (timeout) rsp_error <= 1'b1;
      end
   end

endmodule
